// File: rtl/inst_fetch_resp_pkg.sv
// Shared types and constants for the instruction fetch response path:
// bus widths, the zero/nop word, chip-enable level and fetch FSM states.
package inst_fetch_resp_pkg;

    localparam int INST_ADDR_W       = 32;
    localparam int INST_W            = 32;
    localparam int FETCH_TIMEOUT_DEF = 64;

    localparam logic [INST_W-1:0] ZERO_WORD   = '0;
    localparam logic              CHIP_ENABLE = 1'b1;

    typedef enum logic {
        FETCH_IDLE = 1'b0,
        FETCH_WAIT = 1'b1
    } fetch_state_e;

    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] a);
        return {a[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_resp.sv
// Instruction fetch front end: single-entry line buffer answering hits
// combinationally, refilled from backing memory with a bounded wait.
module inst_fetch_resp
    import inst_fetch_resp_pkg::*;
#(
    parameter int TIMEOUT = FETCH_TIMEOUT_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ce_i,
    input  logic [INST_ADDR_W-1:0] addr_i,
    input  logic                   flush_i,
    output logic [INST_W-1:0]      inst_o,
    output logic                   stallreq_o,
    output logic                   bus_err_o,
    output logic                   mem_req_o,
    output logic [INST_ADDR_W-1:0] mem_addr_o,
    input  logic [INST_W-1:0]      mem_data_i,
    input  logic                   mem_ack_i
);

    localparam logic [7:0] CNT_TERM = 8'(TIMEOUT - 1);

    fetch_state_e          state_q, state_d;
    logic                  valid_q;
    logic [31:2]           tag_q;
    logic [INST_W-1:0]     data_q;
    logic [INST_ADDR_W-1:0] mem_addr_q;
    logic [7:0]            cnt_q;
    logic                  discard_q;
    logic                  bus_err_q;

    logic aligned, fetch_on, hit, miss;
    logic start_req, ack_done, timeout_hit, fill;

    assign aligned  = (addr_i[1:0] == 2'b00);
    assign fetch_on = (ce_i == CHIP_ENABLE);
    assign hit      = fetch_on && aligned && valid_q && (tag_q == addr_i[31:2]);
    assign miss     = fetch_on && aligned && !hit;

    assign inst_o     = hit ? data_q : ZERO_WORD;
    assign stallreq_o = miss;
    assign mem_req_o  = (state_q == FETCH_WAIT);
    assign mem_addr_o = mem_addr_q;
    assign bus_err_o  = bus_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        start_req   = 1'b0;
        ack_done    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            FETCH_IDLE: begin
                if (miss) begin
                    state_d   = FETCH_WAIT;
                    start_req = 1'b1;
                end
            end
            FETCH_WAIT: begin
                // An ack on the terminal-count cycle still counts as a normal fill.
                if (mem_ack_i) begin
                    ack_done = 1'b1;
                    state_d  = FETCH_IDLE;
                end else if (cnt_q == CNT_TERM) begin
                    timeout_hit = 1'b1;
                    state_d     = FETCH_IDLE;
                end
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    assign fill = (ack_done || timeout_hit) && !discard_q && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            tag_q      <= '0;
            data_q     <= ZERO_WORD;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            discard_q  <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            bus_err_q <= (fetch_on && !aligned) || timeout_hit;

            if (start_req) begin
                mem_addr_q <= word_align(addr_i);
                cnt_q      <= '0;
            end else if ((state_q == FETCH_WAIT) && !ack_done && !timeout_hit) begin
                cnt_q <= cnt_q + 8'd1;
            end

            if (start_req || ack_done || timeout_hit) begin
                discard_q <= 1'b0;
            end else if (flush_i && (state_q == FETCH_WAIT)) begin
                discard_q <= 1'b1;
            end

            // A timed-out fetch leaves a nop in the buffer so the CPU can move on.
            if (fill) begin
                valid_q <= 1'b1;
                tag_q   <= mem_addr_q[31:2];
                data_q  <= ack_done ? mem_data_i : ZERO_WORD;
            end else if (flush_i) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/inst_fetch_resp.md
INST_FETCH_RESP -- requirements
Module: inst_fetch_resp

Interface
REQ-001 Parameter: TIMEOUT, default 64, maximum cycles WAIT holds mem_req_o without mem_ack_i.
REQ-002 Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 ce_i  in  1  CPU fetch enable (`ChipEnable = 1).
REQ-006 addr_i  in  32 (`InstAddrBus)  CPU fetch byte address.
REQ-007 flush_i  in  1  invalidate line buffer, discard outstanding fill.
REQ-008 inst_o  out  32 (`InstBus)  instruction to CPU.
REQ-009 stallreq_o  out  1  CPU pipeline stall request.
REQ-010 bus_err_o  out  1  one-cycle error pulse (misalign or timeout).
REQ-011 mem_req_o  out  1  backing-memory read request, level.
REQ-012 mem_addr_o  out  32  word-aligned backing-memory address.
REQ-013 mem_data_i  in  32  backing-memory read data, valid with mem_ack_i.
REQ-014 mem_ack_i  in  1  one-cycle completion strobe.

Function
REQ-015 Single-entry line buffer: valid_q, tag_q[31:2], data_q[31:0].
REQ-016 FSM states: IDLE, WAIT; mem_req_o = 1 only in WAIT; mem_addr_o registered, stable through WAIT.
REQ-017 ce_i=0: inst_o=`ZeroWord, stallreq_o=0, no new request, no bus_err_o.
REQ-018 Hit: ce_i=1, addr_i[1:0]=0, valid_q=1, tag_q=addr_i[31:2] -> inst_o=data_q, stallreq_o=0, same cycle (combinational).
REQ-019 Miss: ce_i=1, aligned, not hit -> stallreq_o=1 same cycle, inst_o=`ZeroWord; in IDLE, FSM to WAIT next edge, mem_addr_o={addr_i[31:2],2'b00}.
REQ-020 WAIT: mem_ack_i sampled each cycle; on ack, data_q<=mem_data_i, tag_q<=mem_addr_o[31:2], valid_q<=1, FSM->IDLE.
REQ-021 Minimum miss latency: miss at cycle 0, mem_req_o at cycle 1, ack at cycle 1, hit with stallreq_o=0 at cycle 2.
REQ-022 Outstanding request never cancelled: addr_i change or ce_i drop during WAIT -> transaction completes and fills buffer with the original address; a new miss starts only from IDLE.
REQ-023 Misaligned (ce_i=1, addr_i[1:0]!=0): inst_o=`ZeroWord, stallreq_o=0, bus_err_o pulses next cycle, no request issued.
REQ-024 Timeout: 8-bit wait counter cleared on WAIT entry; when it reaches TIMEOUT-1 with no ack -> FSM->IDLE, mem_req_o drops, bus_err_o pulses one cycle, buffer filled with `ZeroWord for that tag (CPU proceeds with nop).
REQ-025 Ack on the timeout-terminal cycle: ack wins, normal fill, no bus_err_o.
REQ-026 flush_i: valid_q<=0 next edge; in WAIT, marks fill discarded -> on ack FSM->IDLE, valid_q stays 0.
REQ-027 flush_i with mem_ack_i same cycle: data discarded, valid_q=0.
REQ-028 flush_i with hit same cycle: hit output returned this cycle; invalid from next cycle.

Reset
REQ-029 Reset: FSM=IDLE, valid_q=0, tag_q=0, data_q=`ZeroWord, counter=0, discard flag=0, mem_req_o=0, mem_addr_o=0, bus_err_o=0.
REQ-030 Reset in WAIT: request abandoned, mem_req_o=0 from the next cycle; a late mem_ack_i after reset is ignored.
REQ-031 During reset, with ce_i=0: inst_o=`ZeroWord, stallreq_o=0.

Structure
REQ-032 defines.v SHALL hold `InstAddrBus, `InstBus, `ZeroWord, `ChipEnable, state encodings `FetchIdle/`FetchWait, and `FetchTimeoutDef (64).
REQ-033 Single module, no sub-module; line buffer and counter inline.

Verification
REQ-034 Cold miss: ce_i=1, addr_i=0x0000_0004, ack at cycle 3 with 0x3401_0020 -> stallreq_o cycles 0-3, inst_o=0x3401_0020 at cycle 4, stallreq_o=0.
REQ-035 Hit: same address repeated 5 cycles -> no mem_req_o, inst_o constant, stallreq_o=0.
REQ-036 Address change mid-WAIT: 0x8 -> 0xC at cycle 1, ack at cycle 2 (0x1111_1111) -> tag=0x8 filled, new request 0xC at cycle 4.
REQ-037 Timeout: TIMEOUT=4, never ack -> mem_req_o high 4 cycles, bus_err_o one pulse, inst_o=`ZeroWord, stallreq_o=0.
REQ-038 Flush+ack same cycle: ack 0xDEAD_BEEF with flush_i=1 -> valid_q=0, re-request same address next cycle.
REQ-039 Misalign and reset: addr_i=0x0000_0006 -> bus_err_o pulse, no mem_req_o; rst asserted during WAIT -> mem_req_o=0 next cycle, later ack ignored.
